// File: rtl/clk3_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : clk3_tick_timer
// Description : Programmable periodic / one-shot tick timer running in the
//               divided clk3 domain. A prescaler feeds a period down-counter.
//               Each terminal count gives a 1-cycle tick. The tick sets a
//               sticky irq and loads a single-entry event record that is
//               drained with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module clk3_tick_timer #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk3,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_clr,
  output logic             running,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             irq,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_seq,
  input  logic             evt_ready,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [EVT_W-1:0] EVT_ONE = {{(EVT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  // Configuration captured on start and refreshed at every reload, so a
  // mid-period change to the cfg inputs only takes effect at a boundary.
  logic [PRE_W-1:0] prescale_q;
  logic             oneshot_q;
  logic [EVT_W-1:0] seq_cnt;

  // Prescaler terminal: one count-down enable every (prescale_q+1) cycles.
  logic en;
  // Downstream consumes the held record on this edge.
  logic accept;

  assign en     = (state == ST_RUN) && (prescaler == prescale_q);
  assign accept = evt_valid & evt_ready;

  // Control FSM with prescaler, down-counter and registered tick/running.
  // Priority: stop over start over normal counting.
  always_ff @(posedge clk3) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      count      <= '0;
      prescaler  <= '0;
      prescale_q <= '0;
      oneshot_q  <= 1'b0;
      tick       <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (stop) begin
        // Hold count and prescaler where they are.
        state   <= ST_IDLE;
        running <= 1'b0;
      end else if (start) begin
        // Load (or restart from RUN): fresh period, prescaler cleared.
        state      <= ST_RUN;
        running    <= 1'b1;
        count      <= cfg_period;
        prescaler  <= '0;
        prescale_q <= cfg_prescale;
        oneshot_q  <= cfg_oneshot;
      end else if (state == ST_RUN) begin
        if (en) begin
          prescaler <= '0;
          if (count != '0) begin
            count <= count - CNT_ONE;
          end else begin
            tick <= 1'b1;
            if (oneshot_q) begin
              // Count stays at zero and the timer parks until restarted.
              state   <= ST_DONE;
              running <= 1'b0;
            end else begin
              count      <= cfg_period;
              prescale_q <= cfg_prescale;
              oneshot_q  <= cfg_oneshot;
            end
          end
        end else begin
          prescaler <= prescaler + PRE_ONE;
        end
      end
    end
  end

  // Sticky interrupt: a tick pulse sets it and wins over a coincident clear.
  always_ff @(posedge clk3) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (tick) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

  // Single-entry event record. A tick loads it when empty or when the held
  // record leaves on the same edge; otherwise the new event is dropped and
  // overrun latches. The sequence counter advances on every tick either way.
  always_ff @(posedge clk3) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_seq   <= '0;
      seq_cnt   <= '0;
      overrun   <= 1'b0;
    end else if (tick) begin
      seq_cnt <= seq_cnt + EVT_ONE;
      if (!evt_valid || accept) begin
        evt_valid <= 1'b1;
        evt_seq   <= seq_cnt;
      end else begin
        overrun <= 1'b1;
      end
    end else if (accept) begin
      evt_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk3_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk3_tick_timer
// Description : Directed self-checking bench for clk3_tick_timer. Inputs are
//               driven and outputs sampled 1 ns after each rising clk3 edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk3_tick_timer;

  localparam int CNT_W = 16;
  localparam int PRE_W = 4;
  localparam int EVT_W = 8;

  logic             clk3 = 1'b0;
  logic             rst_n;
  logic [CNT_W-1:0] cfg_period;
  logic [PRE_W-1:0] cfg_prescale;
  logic             cfg_oneshot;
  logic             start;
  logic             stop;
  logic             irq_clr;
  logic             running;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             irq;
  logic             evt_valid;
  logic [EVT_W-1:0] evt_seq;
  logic             evt_ready;
  logic             overrun;

  int checks   = 0;
  int failures = 0;

  // 30 ns clk3
  always #15 clk3 = ~clk3;

  clk3_tick_timer #(
    .CNT_W(CNT_W),
    .PRE_W(PRE_W),
    .EVT_W(EVT_W)
  ) dut (
    .clk3        (clk3),
    .rst_n       (rst_n),
    .cfg_period  (cfg_period),
    .cfg_prescale(cfg_prescale),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
    .irq_clr     (irq_clr),
    .running     (running),
    .count       (count),
    .tick        (tick),
    .irq         (irq),
    .evt_valid   (evt_valid),
    .evt_seq     (evt_seq),
    .evt_ready   (evt_ready),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk3);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    irq_clr   = 1'b0;
    evt_ready = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  // Returns 1 ns after the start edge (E0).
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    cfg_period   = '0;
    cfg_prescale = '0;
    cfg_oneshot  = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    irq_clr      = 1'b0;
    evt_ready    = 1'b0;

    // ---- 1: reset values, then idle with no start ----
    step(3);
    check("rst_running",   32'(running),   0);
    check("rst_count",     32'(count),     0);
    check("rst_tick",      32'(tick),      0);
    check("rst_irq",       32'(irq),       0);
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_evt_seq",   32'(evt_seq),   0);
    check("rst_overrun",   32'(overrun),   0);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (tick) n++;
    end
    check("idle_no_tick", 32'(n), 0);
    check("idle_running", 32'(running), 0);

    // ---- 2: periodic, period=3 prescale=1 -> tick every 8 cycles ----
    do_reset();
    cfg_period   = 16'd3;
    cfg_prescale = 4'd1;
    cfg_oneshot  = 1'b0;
    evt_ready    = 1'b1;
    pulse_start();
    check("per_running", 32'(running), 1);
    check("per_load",    32'(count),   3);
    for (int k = 1; k <= 25; k++) begin
      step(1);
      check("per_tick", 32'(tick), ((k % 8) == 0) ? 1 : 0);
      if (k == 2) check("per_count_dec", 32'(count), 2);
      if (k == 9) check("per_irq", 32'(irq), 1);
      if (k > 8 && (k % 8) == 1) begin
        check("per_evt_valid", 32'(evt_valid), 1);
        check("per_evt_seq",   32'(evt_seq),   32'(k / 8 - 1));
      end
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_running", 32'(running), 0);
    check("stop_hold",    32'(count),   3);
    step(5);
    check("stop_hold2",   32'(count),   3);
    check("stop_tick",    32'(tick),    0);
    check("stop_irq_kept", 32'(irq),    1);

    // ---- 3: one-shot, period=2 prescale=0 ----
    do_reset();
    cfg_period   = 16'd2;
    cfg_prescale = 4'd0;
    cfg_oneshot  = 1'b1;
    evt_ready    = 1'b1;
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      for (int k = 1; k <= 4; k++) begin
        step(1);
        check("os_tick", 32'(tick), (k == 3) ? 1 : 0);
        if (k == 3) begin
          check("os_running", 32'(running), 0);
          check("os_count",   32'(count),   0);
        end
        if (k == 4) begin
          check("os_evt_valid", 32'(evt_valid), 1);
          check("os_evt_seq",   32'(evt_seq),   32'(r));
        end
      end
      step(3);
      check("os_done_tick",  32'(tick),  0);
      check("os_done_count", 32'(count), 0);
    end

    // ---- 4: backpressure, period=0 prescale=1, tick every 2 cycles ----
    do_reset();
    cfg_period   = 16'd0;
    cfg_prescale = 4'd1;
    cfg_oneshot  = 1'b0;
    evt_ready    = 1'b0;
    pulse_start();
    step(2);
    check("bp_tick1", 32'(tick), 1);
    step(1);
    check("bp_valid1",   32'(evt_valid), 1);
    check("bp_seq1",     32'(evt_seq),   0);
    check("bp_overrun0", 32'(overrun),   0);
    step(1);
    check("bp_tick2",    32'(tick),      1);
    step(1);
    check("bp_overrun1", 32'(overrun),   1);
    check("bp_seq_held", 32'(evt_seq),   0);
    check("bp_valid2",   32'(evt_valid), 1);
    step(1);
    check("bp_tick3",    32'(tick),      1);
    evt_ready = 1'b1;
    step(1);
    check("bp_valid3",   32'(evt_valid), 1);
    check("bp_seq_load", 32'(evt_seq),   2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    check("bp_drained",      32'(evt_valid), 0);
    check("bp_overrun_kept", 32'(overrun),   1);
    evt_ready = 1'b0;

    // ---- 5: control collisions ----
    do_reset();
    cfg_period   = 16'd5;
    cfg_prescale = 4'd0;
    cfg_oneshot  = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    check("ss_running", 32'(running), 0);
    check("ss_count",   32'(count),   0);
    step(2);
    check("ss_tick",    32'(tick),    0);

    cfg_period = 16'd1;
    pulse_start();
    step(2);
    check("col_tick", 32'(tick), 1);
    irq_clr = 1'b1;
    step(1);
    check("col_irq_set_wins", 32'(irq), 1);
    step(1);
    irq_clr = 1'b0;
    check("col_irq_cleared", 32'(irq),  0);
    check("col_tick2",       32'(tick), 1);
    step(1);
    check("col_irq_reset",   32'(irq),  1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;

    cfg_period = 16'd3;
    pulse_start();
    step(2);
    check("rs_count1", 32'(count), 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("rs_reload", 32'(count), 3);
    check("rs_tick0",  32'(tick),  0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("rs_tick", 32'(tick), (k == 4) ? 1 : 0);
    end

    // ---- 6: reset one cycle before the expected tick ----
    do_reset();
    cfg_period   = 16'd3;
    cfg_prescale = 4'd0;
    cfg_oneshot  = 1'b0;
    evt_ready    = 1'b1;
    pulse_start();
    step(2);
    check("mr_count", 32'(count), 1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("mr_running", 32'(running), 0);
    check("mr_count0",  32'(count),   0);
    check("mr_tick0",   32'(tick),    0);
    step(1);
    check("mr_no_tick", 32'(tick),    0);
    step(1);
    check("mr_evt_valid", 32'(evt_valid), 0);
    check("mr_irq",       32'(irq),       0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (tick) n++;
    end
    check("mr_quiet", 32'(n), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
